// File: rtl/cpu_run_sequencer.sv
// Run controller for the CPU core: sequences core reset, runs it for a fixed
// window, folds ALU activity into a MISR and reports pass/fail at the end.
module cpu_run_sequencer #(
  parameter int          DATA_W        = 32,
  parameter int          STAT_W        = 5,
  parameter int          FAULT_W       = 8,
  parameter int          CNT_W         = 16,
  parameter int          RST_DELAY     = 2,
  parameter int          RST_CYCLES    = 2,
  parameter int          RUN_CYCLES    = 10,
  parameter logic [31:0] POLY          = 32'h04C11DB7,
  parameter bit          STOP_ON_FAULT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [STAT_W-1:0]  alu_status,
  input  logic [FAULT_W-1:0] seg_faults,
  input  logic [DATA_W-1:0]  expected_sig,
  output logic               cpu_rst,
  output logic               running,
  output logic               done,
  output logic               pass,
  output logic [FAULT_W-1:0] fault_vec,
  output logic [DATA_W-1:0]  signature,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [DATA_W-1:0] POLY_W  = DATA_W'(POLY);
  localparam logic [31:0]       PRE_LD  = 32'(RST_DELAY - 1);
  localparam logic [31:0]       HOLD_LD = 32'(RST_CYCLES - 1);
  localparam logic [31:0]       RUN_LD  = 32'(RUN_CYCLES - 1);

  logic [2:0]         state;
  logic [31:0]        cnt;
  logic [DATA_W-1:0]  sig_next;
  logic [FAULT_W-1:0] fv_next;
  logic               fault_stop;
  logic               run_last;

  assign sig_next = {signature[DATA_W-2:0], 1'b0}
                  ^ (signature[DATA_W-1] ? POLY_W : '0)
                  ^ alu_result
                  ^ DATA_W'(alu_status);
  assign fv_next    = fault_vec | seg_faults;
  assign fault_stop = STOP_ON_FAULT && (|seg_faults);
  assign run_last   = (cnt == 32'd0) || fault_stop;

  // cpu_rst follows rst combinationally so the core is held the whole time
  assign cpu_rst = rst | (state == S_HOLD);
  assign running = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      signature   <= '0;
      fault_vec   <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            signature   <= '0;
            fault_vec   <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            if (RST_DELAY == 0) begin
              state <= S_HOLD;
              cnt   <= HOLD_LD;
            end else begin
              state <= S_PRE;
              cnt   <= PRE_LD;
            end
          end
        end
        S_PRE: begin
          if (cnt == 32'd0) begin
            state <= S_HOLD;
            cnt   <= HOLD_LD;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_HOLD: begin
          if (cnt == 32'd0) begin
            state <= S_RUN;
            cnt   <= RUN_LD;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_RUN: begin
          signature <= sig_next;
          fault_vec <= fv_next;
          if (~&cycle_count)
            cycle_count <= cycle_count + CNT_W'(1);
          if (run_last) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (fv_next == '0) && (sig_next == expected_sig);
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: three configurations share one stimulus and
// are checked every cycle against a timeline-based reference model.
module tb_cpu_run_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] alu_result;
  logic [4:0]  alu_status;
  logic [7:0]  seg_faults;
  logic [31:0] expected_sig;

  logic        cpu_rst     [3];
  logic        running     [3];
  logic        done        [3];
  logic        pass        [3];
  logic [7:0]  fault_vec   [3];
  logic [31:0] signature   [3];
  logic [15:0] cycle_count [3];

  int total = 0;
  int bad   = 0;

  // per-instance configuration: delay, hold width, stop-on-fault
  int md [3] = '{2, 2, 0};
  int mh [3] = '{2, 2, 1};
  bit ms [3] = '{1'b1, 1'b0, 1'b1};
  localparam int R = 4;

  bit          m_act  [3];
  bit          m_done [3];
  bit          m_pass [3];
  int          m_k    [3];
  logic [31:0] m_sig  [3];
  logic [7:0]  m_fv   [3];
  int          m_cc   [3];

  always #5 clk = ~clk;

  cpu_run_sequencer #(.RUN_CYCLES(R)) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .alu_result(alu_result), .alu_status(alu_status),
    .seg_faults(seg_faults), .expected_sig(expected_sig),
    .cpu_rst(cpu_rst[0]), .running(running[0]), .done(done[0]),
    .pass(pass[0]), .fault_vec(fault_vec[0]),
    .signature(signature[0]), .cycle_count(cycle_count[0])
  );

  cpu_run_sequencer #(.RUN_CYCLES(R), .STOP_ON_FAULT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .alu_result(alu_result), .alu_status(alu_status),
    .seg_faults(seg_faults), .expected_sig(expected_sig),
    .cpu_rst(cpu_rst[1]), .running(running[1]), .done(done[1]),
    .pass(pass[1]), .fault_vec(fault_vec[1]),
    .signature(signature[1]), .cycle_count(cycle_count[1])
  );

  cpu_run_sequencer #(.RUN_CYCLES(R), .RST_DELAY(0), .RST_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .start(start),
    .alu_result(alu_result), .alu_status(alu_status),
    .seg_faults(seg_faults), .expected_sig(expected_sig),
    .cpu_rst(cpu_rst[2]), .running(running[2]), .done(done[2]),
    .pass(pass[2]), .fault_vec(fault_vec[2]),
    .signature(signature[2]), .cycle_count(cycle_count[2])
  );

  function automatic logic [31:0] misr(input logic [31:0] s,
                                       input logic [31:0] d,
                                       input logic [4:0]  st);
    logic [31:0] fb;
    fb = s[31] ? 32'h04C11DB7 : 32'h0;
    return ({s[30:0], 1'b0} ^ fb) ^ d ^ {27'b0, st};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // k counts edges since the start edge; phases are windows on k
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_k[i] = 0;
        m_sig[i] = '0; m_fv[i] = '0; m_cc[i] = 0;
      end else if (start && (!m_act[i] || m_done[i])) begin
        m_act[i] = 1; m_done[i] = 0; m_pass[i] = 0; m_k[i] = 0;
        m_sig[i] = '0; m_fv[i] = '0; m_cc[i] = 0;
      end else if (m_act[i] && !m_done[i]) begin
        bit in_run;
        in_run = m_k[i] >= md[i] + mh[i];
        if (in_run) begin
          m_sig[i] = misr(m_sig[i], alu_result, alu_status);
          m_fv[i]  = m_fv[i] | seg_faults;
          if (m_cc[i] < 65535) m_cc[i]++;
        end
        m_k[i]++;
        if (in_run && (m_k[i] == md[i] + mh[i] + R ||
                       (ms[i] && seg_faults != 0))) begin
          m_done[i] = 1;
          m_pass[i] = (m_fv[i] == 0) && (m_sig[i] == expected_sig);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      bit live;
      logic e_rst, e_run;
      live  = m_act[i] && !m_done[i];
      e_rst = rst | (live && m_k[i] >= md[i] && m_k[i] < md[i] + mh[i]);
      e_run = live && m_k[i] >= md[i] + mh[i];
      chk($sformatf("u%0d.cpu_rst", i), 32'(cpu_rst[i]), 32'(e_rst));
      chk($sformatf("u%0d.running", i), 32'(running[i]), 32'(e_run));
      chk($sformatf("u%0d.done", i), 32'(done[i]), 32'(m_done[i]));
      chk($sformatf("u%0d.pass", i), 32'(pass[i]), 32'(m_pass[i]));
      chk($sformatf("u%0d.fault_vec", i), 32'(fault_vec[i]), 32'(m_fv[i]));
      chk($sformatf("u%0d.signature", i), signature[i], m_sig[i]);
      chk($sformatf("u%0d.cycle_count", i), 32'(cycle_count[i]),
          32'(m_cc[i]));
    end
  endtask

  task automatic step(input bit s, input bit r, input logic [31:0] res,
                      input logic [4:0] st, input logic [7:0] f);
    start = s; rst = r;
    alu_result = res; alu_status = st; seg_faults = f;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    start = 1'b0; rst = 1'b0;
  endtask

  logic [31:0] rres [13];
  logic [4:0]  rst_s [13];
  logic [7:0]  rflt [13];

  initial begin
    rst = 1'b1; start = 1'b0; alu_result = '0; alu_status = '0;
    seg_faults = '0; expected_sig = 32'h0000000F;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_k[i] = 0;
      m_sig[i] = '0; m_fv[i] = '0; m_cc[i] = 0;
    end
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("reset.cpu_rst", 32'(cpu_rst[0]), 32'd1);
    chk("reset.done", 32'(done[0]), 32'd0);
    chk("reset.sig", signature[0], 32'd0);
    step(0, 0, 0, 0, 0);
    chk("idle.cpu_rst", 32'(cpu_rst[0]), 32'd0);

    // timing, ignored start in RUN, signature 0xF
    step(1, 0, 1, 0, 0);
    chk("t1.e0.cpu_rst_a", 32'(cpu_rst[0]), 32'd0);
    chk("t5.e0.cpu_rst_c", 32'(cpu_rst[2]), 32'd1);
    step(0, 0, 1, 0, 0);
    chk("t5.e1.cpu_rst_c", 32'(cpu_rst[2]), 32'd0);
    step(0, 0, 1, 0, 0);
    chk("t1.e2.cpu_rst_a", 32'(cpu_rst[0]), 32'd1);
    for (int j = 3; j <= 9; j++) step(j == 5, 0, 1, 0, 0);
    chk("t2.sig", signature[0], 32'h0000000F);
    chk("t2.cc", 32'(cycle_count[0]), 32'd4);
    chk("t2.pass", 32'(pass[0]), 32'd1);
    chk("t2.done", 32'(done[0]), 32'd1);

    // restart from DONE with a wrong golden value
    expected_sig = 32'h0000000E;
    step(1, 0, 1, 0, 0);
    chk("t6.cleared.done", 32'(done[0]), 32'd0);
    chk("t6.cleared.sig", signature[0], 32'd0);
    for (int j = 1; j <= 9; j++) step(0, 0, 1, 0, 0);
    chk("t2.bad_pass", 32'(pass[0]), 32'd0);
    chk("t6.sig_again", signature[0], 32'h0000000F);

    // fault in second RUN cycle
    expected_sig = 32'h0000000F;
    step(1, 0, 1, 0, 0);
    for (int j = 1; j <= 9; j++) step(0, 0, 1, 0, (j == 6) ? 8'h04 : 8'h00);
    chk("t3.stop.cc", 32'(cycle_count[0]), 32'd2);
    chk("t3.stop.fv", 32'(fault_vec[0]), 32'h04);
    chk("t3.stop.pass", 32'(pass[0]), 32'd0);
    chk("t3.nostop.cc", 32'(cycle_count[1]), 32'd4);
    chk("t3.nostop.fv", 32'(fault_vec[1]), 32'h04);
    chk("t3.nostop.pass", 32'(pass[1]), 32'd0);

    // reset mid-RUN, then a clean rerun
    step(1, 0, 1, 0, 0);
    for (int j = 1; j <= 5; j++) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("t4.cpu_rst", 32'(cpu_rst[0]), 32'd1);
    chk("t4.running", 32'(running[0]), 32'd0);
    chk("t4.sig", signature[0], 32'd0);
    step(1, 0, 1, 0, 0);
    for (int j = 1; j <= 9; j++) step(0, 0, 1, 0, 0);
    chk("t4.rerun.sig", signature[0], 32'h0000000F);
    chk("t4.rerun.pass", 32'(pass[0]), 32'd1);

    // randomized sequences
    for (int s = 0; s < 24; s++) begin
      logic [31:0] g;
      for (int j = 0; j < 13; j++) begin
        rres[j]  = $urandom;
        rst_s[j] = 5'($urandom);
        rflt[j]  = ($urandom_range(0, 7) == 0) ?
                   8'($urandom_range(1, 255)) : 8'h00;
      end
      g = '0;
      for (int j = 5; j <= 8; j++) g = misr(g, rres[j], rst_s[j]);
      expected_sig = ($urandom_range(0, 1) == 1) ? g : (g ^ 32'h1);
      step(1, 0, rres[0], rst_s[0], rflt[0]);
      for (int j = 1; j < 13; j++)
        step(($urandom_range(0, 5) == 0), (s % 7 == 3) && (j == 6),
             rres[j], rst_s[j], rflt[j]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
